// File: rtl/stt_fsm_arbiter_if.sv
// Requester/response bundle between the requesters and the shared-FSM arbiter.
interface stt_fsm_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int IN_W  = 4,
  parameter int OUT_W = 8,
  parameter int ID_W  = $clog2(NREQ)
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IN_W-1:0] req_sym;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [OUT_W-1:0]     rsp_data;
  logic                 rsp_err;

  modport master (
    output req_valid, req_sym, req_last,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_sym, req_last,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/stt_fsm_arbiter.sv
// Round-robin arbiter sharing one symbol-driven FSM among NREQ requesters,
// with burst locking, lock timeout, illegal-symbol rejection and tagged responses.
module stt_fsm_arbiter #(
  parameter int NREQ     = 4,
  parameter int IN_W     = 4,
  parameter int OUT_W    = 8,
  parameter int MAX_SYM  = 9,
  parameter int NOP_SYM  = 15,
  parameter int LOCK_TMO = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  stt_fsm_arbiter_if.slave bus,
  output logic [IN_W-1:0]  fsm_in,
  input  logic [OUT_W-1:0] fsm_out,
  output logic             lock_tmo
);
  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(LOCK_TMO + 1);
  localparam logic [IN_W-1:0]  MAX_S    = IN_W'(MAX_SYM);
  localparam logic [IN_W-1:0]  NOP_S    = IN_W'(NOP_SYM);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TMO - 1);

  typedef enum logic [1:0] {ARB, EXEC, CAPT, RESP} state_e;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   fsm_in_q;
  logic [ID_W-1:0]   rr_last_q, owner_q, id_q, gnt_id;
  logic              locked_q, last_q, rsp_err_q;
  logic [OUT_W-1:0]  rsp_data_q;
  logic [CNT_W-1:0]  tmo_cnt_q;
  logic              gnt_found, do_grant, gnt_legal, idle_locked, tmo_hit;
  logic [IN_W-1:0]   gnt_sym;
  int unsigned       rr_idx;

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    rr_idx    = 0;
    if (locked_q) begin
      gnt_found = bus.req_valid[owner_q];
      gnt_id    = owner_q;
    end else begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        rr_idx = (32'(rr_last_q) + k) % NREQ;
        if (!gnt_found && bus.req_valid[ID_W'(rr_idx)]) begin
          gnt_found = 1'b1;
          gnt_id    = ID_W'(rr_idx);
        end
      end
    end
  end

  always_comb begin
    gnt_sym = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (ID_W'(k) == gnt_id) gnt_sym = bus.req_sym[k*IN_W +: IN_W];
    end
  end

  // Grants and responses are masked while reset is held so no handshake is seen.
  assign do_grant    = rst_n && (state_q == ARB) && gnt_found;
  assign gnt_legal   = (gnt_sym <= MAX_S);
  assign idle_locked = (state_q == ARB) && locked_q && !bus.req_valid[owner_q];
  assign tmo_hit     = idle_locked && (tmo_cnt_q == TMO_LAST);

  assign lock_tmo      = rst_n && tmo_hit;
  assign bus.req_ready = do_grant ? (NREQ'(1) << gnt_id) : '0;
  assign bus.rsp_valid = rst_n && (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign fsm_in        = fsm_in_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB:     if (do_grant) state_d = gnt_legal ? EXEC : RESP;
      EXEC:    state_d = CAPT;
      CAPT:    state_d = RESP;
      RESP:    state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB;
      fsm_in_q   <= NOP_S;
      rr_last_q  <= ID_W'(NREQ - 1);
      locked_q   <= 1'b0;
      owner_q    <= '0;
      tmo_cnt_q  <= '0;
      id_q       <= '0;
      last_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      // Symbol is presented only during EXEC; every other cycle sees NOP.
      fsm_in_q <= (do_grant && gnt_legal) ? gnt_sym : NOP_S;
      if (do_grant) begin
        rr_last_q  <= gnt_id;
        id_q       <= gnt_id;
        last_q     <= bus.req_last[gnt_id];
        rsp_err_q  <= !gnt_legal;
        rsp_data_q <= '0;
      end
      if (state_q == CAPT) rsp_data_q <= fsm_out;
      if (state_q == RESP) begin
        locked_q <= !last_q;
        owner_q  <= id_q;
      end else if (tmo_hit) begin
        locked_q <= 1'b0;
      end
      if (do_grant || (state_q == RESP) || tmo_hit) tmo_cnt_q <= '0;
      else if (idle_locked)                         tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_stt_fsm_arbiter.sv
// Bench for stt_fsm_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_stt_fsm_arbiter;
  localparam int NREQ = 4, IN_W = 4, OUT_W = 8, LOCK_TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [IN_W-1:0]  fsm_in;
  logic [OUT_W-1:0] fsm_out;
  logic             lock_tmo;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  stt_fsm_arbiter_if #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  stt_fsm_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .MAX_SYM(9),
                    .NOP_SYM(15), .LOCK_TMO(LOCK_TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .fsm_in(fsm_in), .fsm_out(fsm_out), .lock_tmo(lock_tmo)
  );

  // Stub FSM: code = symbol + 0x10, one cycle after sampling.
  always @(posedge clk) fsm_out <= {4'h0, fsm_in} + 8'h10;

  typedef struct {
    bit         rst;
    logic [3:0] valid;
    logic [3:0] sym;
    logic [3:0] exp_ready;
    int         exp_id;
    logic [7:0] exp_data;
    bit         exp_err;
  } vec_t;

  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
    bit         err;
    bit         last;
  } exp_t;

  vec_t tbl[8];
  exp_t rq[$];

  logic [3:0] g, acc, exp_ready, sym_r;
  logic [1:0] rid;
  logic [7:0] rdata;
  logic       rerr;
  int m_rr, m_owner, m_idle, m_busy, gi, exp_fsm, next_fsm, bcnt;
  int tmo_at, gnt_at, tmo_pulses;
  bit m_locked, exp_tmo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no event within bound at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic drive(input int i, input bit v, input int sym, input bit last);
    bus.req_valid[i] = v;
    bus.req_sym[i*IN_W +: IN_W] = IN_W'(sym);
    bus.req_last[i] = last;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_sym   = '0;
    bus.req_last  = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Returns at the negedge of the grant cycle.
  task automatic wait_grant(output logic [3:0] gr, input int lim, input string name);
    gr = '0;
    for (int c = 0; c < lim; c++) begin
      samp();
      if (bus.req_ready != 0) begin
        gr = bus.req_ready;
        return;
      end
      step();
    end
    fail_tmo(name);
  endtask

  // Returns at the negedge of the response cycle.
  task automatic wait_rsp(output logic [1:0] id, output logic [7:0] data, output logic err,
                          input int lim, input string name);
    id = '0; data = '0; err = 1'b0;
    for (int c = 0; c < lim; c++) begin
      samp();
      if (bus.rsp_valid) begin
        id = bus.rsp_id; data = bus.rsp_data; err = bus.rsp_err;
        return;
      end
      step();
    end
    fail_tmo(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 4'b1111, 4'd3,  4'b0001, 0, 8'h13, 1'b0};
    tbl[1] = '{1'b0, 4'b1111, 4'd5,  4'b0010, 1, 8'h15, 1'b0};
    tbl[2] = '{1'b0, 4'b1001, 4'd9,  4'b1000, 3, 8'h19, 1'b0};
    tbl[3] = '{1'b0, 4'b0110, 4'd10, 4'b0010, 1, 8'h00, 1'b1};
    tbl[4] = '{1'b0, 4'b0001, 4'd0,  4'b0001, 0, 8'h10, 1'b0};
    tbl[5] = '{1'b1, 4'b1100, 4'd15, 4'b0100, 2, 8'h00, 1'b1};
    tbl[6] = '{1'b0, 4'b1111, 4'd7,  4'b1000, 3, 8'h17, 1'b0};
    tbl[7] = '{1'b0, 4'b1110, 4'd9,  4'b0010, 1, 8'h19, 1'b0};

    // Reset values, with requests pending while reset is held.
    clear_reqs();
    bus.req_valid = '1;
    rst_n = 1'b0;
    step(); step();
    samp();
    chk("rst req_ready", bus.req_ready, 0);
    chk("rst rsp_valid", bus.rsp_valid, 0);
    chk("rst rsp_id", bus.rsp_id, 0);
    chk("rst rsp_data", bus.rsp_data, 0);
    chk("rst rsp_err", bus.rsp_err, 0);
    chk("rst lock_tmo", lock_tmo, 0);
    chk("rst fsm_in", fsm_in, 15);
    step();

    for (int n = 0; n < 8; n++) begin
      if (tbl[n].rst) do_reset();
      for (int i = 0; i < NREQ; i++) drive(i, tbl[n].valid[i], tbl[n].sym, 1'b1);
      wait_grant(g, 20, "tbl grant");
      chk("tbl ready", g, tbl[n].exp_ready);
      step();
      clear_reqs();
      wait_rsp(rid, rdata, rerr, 20, "tbl rsp");
      chk("tbl rsp_id", rid, tbl[n].exp_id);
      chk("tbl rsp_data", rdata, tbl[n].exp_data);
      chk("tbl rsp_err", rerr, tbl[n].exp_err);
      step();
    end

    // Single request: exact latency.
    do_reset();
    drive(2, 1'b1, 3, 1'b1);
    samp(); chk("single ready T", bus.req_ready, 4'b0100); chk("single fsm_in T", fsm_in, 15);
    step(); clear_reqs();
    samp(); chk("single ready T+1", bus.req_ready, 0); chk("single fsm_in T+1", fsm_in, 3);
    chk("single rv T+1", bus.rsp_valid, 0);
    step();
    samp(); chk("single fsm_in T+2", fsm_in, 15); chk("single rv T+2", bus.rsp_valid, 0);
    step();
    samp(); chk("single rv T+3", bus.rsp_valid, 1); chk("single id", bus.rsp_id, 2);
    chk("single data", bus.rsp_data, 8'h13); chk("single err", bus.rsp_err, 0);
    step();
    samp(); chk("single rv T+4", bus.rsp_valid, 0);
    step();

    // Fairness with all requesters continuously valid.
    do_reset();
    for (int i = 0; i < NREQ; i++) drive(i, 1'b1, i, 1'b1);
    for (int n = 0; n < 5; n++) begin
      wait_grant(g, 20, "fair grant");
      chk("fair order", g, 4'b0001 << (n % 4));
      step();
      wait_rsp(rid, rdata, rerr, 20, "fair rsp");
      chk("fair rsp_id", rid, n % 4);
      chk("fair rsp_data", rdata, 8'h10 + (n % 4));
      step();
    end

    // Illegal symbol.
    do_reset();
    drive(1, 1'b1, 12, 1'b1);
    samp(); chk("illegal ready", bus.req_ready, 4'b0010); chk("illegal fsm_in T", fsm_in, 15);
    step(); clear_reqs();
    samp(); chk("illegal rv T+1", bus.rsp_valid, 1); chk("illegal err", bus.rsp_err, 1);
    chk("illegal data", bus.rsp_data, 0); chk("illegal id", bus.rsp_id, 1);
    chk("illegal fsm_in T+1", fsm_in, 15);
    step();
    samp(); chk("illegal rv T+2", bus.rsp_valid, 0); chk("illegal fsm_in T+2", fsm_in, 15);
    step();

    // Burst lock keeps requester 3 out until requester 0's burst ends.
    do_reset();
    drive(0, 1'b1, 1, 1'b0);
    drive(3, 1'b1, 5, 1'b1);
    bcnt = 0;
    for (int n = 0; n < 4; n++) begin
      wait_grant(g, 30, "burst grant");
      chk("burst grant", g, (n < 3) ? 4'b0001 : 4'b1000);
      step();
      if (g[0]) begin
        bcnt++;
        if (bcnt < 3) drive(0, 1'b1, bcnt + 1, bcnt == 2);
        else drive(0, 1'b0, 0, 1'b0);
      end else begin
        drive(3, 1'b0, 0, 1'b0);
      end
      wait_rsp(rid, rdata, rerr, 20, "burst rsp");
      chk("burst rsp_id", rid, (n < 3) ? 0 : 3);
      chk("burst rsp_data", rdata, (n < 3) ? 8'h11 + n : 8'h15);
      step();
    end

    // Lock timeout: owner goes quiet, requester 1 waits.
    do_reset();
    drive(0, 1'b1, 1, 1'b0);
    samp(); chk("tmo first grant", bus.req_ready, 4'b0001);
    step();
    drive(0, 1'b0, 0, 1'b0);
    drive(1, 1'b1, 4, 1'b1);
    tmo_at = -1; gnt_at = -1; tmo_pulses = 0; g = '0;
    for (int c = 1; c <= 25; c++) begin
      samp();
      if (lock_tmo) begin
        tmo_pulses++;
        if (tmo_at < 0) tmo_at = c;
      end
      if (bus.req_ready != 0 && gnt_at < 0) begin
        gnt_at = c;
        g = bus.req_ready;
      end
      step();
      if (gnt_at == c) drive(1, 1'b0, 0, 1'b0);
    end
    chk("tmo cycle", tmo_at, 19);
    chk("tmo pulses", tmo_pulses, 1);
    chk("tmo next grant cycle", gnt_at, 20);
    chk("tmo next grant", g, 4'b0010);

    // Reset while in EXEC.
    do_reset();
    drive(1, 1'b1, 4, 1'b1);
    samp(); chk("rexec grant", bus.req_ready, 4'b0010);
    step();
    clear_reqs();
    rst_n = 1'b0;
    drive(0, 1'b1, 6, 1'b1);
    drive(1, 1'b1, 7, 1'b1);
    samp(); chk("rexec fsm_in exec", fsm_in, 4); chk("rexec ready in rst", bus.req_ready, 0);
    step();
    rst_n = 1'b1;
    samp(); chk("rexec fsm_in after", fsm_in, 15); chk("rexec rv after", bus.rsp_valid, 0);
    chk("rexec first grant", bus.req_ready, 4'b0001);
    step(); clear_reqs();
    samp(); chk("rexec rv +1", bus.rsp_valid, 0);
    step();
    samp(); chk("rexec rv +2", bus.rsp_valid, 0);
    step();
    samp(); chk("rexec rv +3", bus.rsp_valid, 1); chk("rexec id", bus.rsp_id, 0);
    chk("rexec data", bus.rsp_data, 8'h16);
    step();

    // Randomized traffic against a transaction-level model.
    do_reset();
    rq.delete();
    m_rr = NREQ - 1; m_locked = 1'b0; m_owner = 0; m_idle = 0; m_busy = 0;
    next_fsm = 15; acc = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      samp();
      exp_fsm = next_fsm;
      next_fsm = 15;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        chk("rnd rsp_valid", bus.rsp_valid, 1);
        chk("rnd rsp_id", bus.rsp_id, rq[0].id);
        chk("rnd rsp_data", bus.rsp_data, rq[0].data);
        chk("rnd rsp_err", bus.rsp_err, rq[0].err);
        m_locked = !rq[0].last;
        m_owner  = rq[0].id;
        m_idle   = 0;
        void'(rq.pop_front());
      end else begin
        chk("rnd rsp_valid", bus.rsp_valid, 0);
      end
      exp_ready = '0;
      exp_tmo = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
      end else begin
        gi = -1;
        if (m_locked) begin
          if (bus.req_valid[m_owner]) gi = m_owner;
          else begin
            m_idle++;
            if (m_idle == LOCK_TMO) begin
              exp_tmo = 1'b1; m_locked = 1'b0; m_idle = 0;
            end
          end
        end else begin
          for (int k = 1; k <= NREQ; k++)
            if (gi < 0 && bus.req_valid[(m_rr + k) % NREQ]) gi = (m_rr + k) % NREQ;
        end
        if (gi >= 0) begin
          sym_r = bus.req_sym[gi*IN_W +: IN_W];
          exp_ready[gi] = 1'b1;
          m_rr = gi;
          m_idle = 0;
          if (sym_r <= 9) begin
            rq.push_back('{cyc + 3, gi, 8'h10 + {4'h0, sym_r}, 1'b0, bus.req_last[gi]});
            m_busy = 3;
            next_fsm = sym_r;
          end else begin
            rq.push_back('{cyc + 1, gi, 8'h00, 1'b1, bus.req_last[gi]});
            m_busy = 1;
          end
        end
      end
      chk("rnd req_ready", bus.req_ready, exp_ready);
      chk("rnd lock_tmo", lock_tmo, exp_tmo);
      chk("rnd fsm_in", fsm_in, exp_fsm);
      acc = bus.req_ready;
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i]) begin
          if ($urandom_range(0, 5) == 0)
            drive(i, 1'b1,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9)),
                  1'($urandom_range(0, 1)));
        end else if ($urandom_range(0, 39) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
